// File: rtl/voice_scheduler_pkg.sv
// Shared constants and types for the voice scheduler.
// Optional feature macro: VOICE_STEAL_EN (oldest-voice stealing when all slots are busy).
package voice_scheduler_pkg;

    localparam int SYNTH_WIDTH          = 16;
    localparam int SYNTH_PHASE_ACC_BITS = 24;
    localparam int NUM_VOICES_DEFAULT   = 4;
    localparam int NOTE_ID_W            = 7;
    localparam int AGE_W                = 8;

    typedef struct packed {
        logic                            active;
        logic [NOTE_ID_W-1:0]            note_id;
        logic [SYNTH_PHASE_ACC_BITS-1:0] incr;
        logic [SYNTH_PHASE_ACC_BITS-1:0] phase;
    } voice_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/voice_scheduler_alloc.sv
// Combinational slot selection: note-id match, lowest free slot and (VOICE_STEAL_EN) oldest victim.
module voice_alloc
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]                active,
    input  logic [NUM_VOICES-1:0][NOTE_ID_W-1:0] ids,
`ifdef VOICE_STEAL_EN
    input  logic [NUM_VOICES-1:0][AGE_W-1:0]     ages,
    output logic [IDX_W-1:0]                     victim_idx,
`endif
    input  logic [NOTE_ID_W-1:0]                 note_id,
    output logic [NUM_VOICES-1:0]                match_vec,
    output logic                                 match_hit,
    output logic [IDX_W-1:0]                     match_idx,
    output logic                                 free_hit,
    output logic [IDX_W-1:0]                     free_idx
);

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_match
        assign match_vec[g] = active[g] && (ids[g] == note_id);
    end

    // Walk from the top so the lowest index is the last (winning) write.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!active[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0] best_age;

    // Strict compare keeps the lowest index on equal ages.
    always_comb begin
        victim_idx = '0;
        best_age   = ages[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (ages[i] > best_age) begin
                best_age   = ages[i];
                victim_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator and per-sample sweep over the shared waveform unit.
// Optional feature macro: VOICE_STEAL_EN.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int PHASE_BITS = SYNTH_PHASE_ACC_BITS,
    parameter int WIDTH      = SYNTH_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    note_valid_in,
    output logic                    note_ready_out,
    input  logic                    note_on_in,
    input  logic [NOTE_ID_W-1:0]    note_id_in,
    input  logic [PHASE_BITS-1:0]   note_incr_in,
    input  logic                    sample_tick_in,
    output logic                    voice_valid_out,
    output logic [PHASE_BITS-1:0]   voice_phase_out,
    input  logic                    wave_valid_in,
    input  logic signed [WIDTH-1:0] wave_sample_in,
    output logic                    mix_valid_out,
    output logic signed [WIDTH-1:0] mix_out,
    output logic [NUM_VOICES-1:0]   active_out,
    output logic                    overrun_out
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = WIDTH + IDX_W;
    localparam logic [IDX_W:0] V_END = (IDX_W + 1)'(NUM_VOICES);

    sched_state_t                        state, state_nx;
    voice_t [NUM_VOICES-1:0]             voice;
    logic [NUM_VOICES-1:0]               active_vec, match_vec;
    logic [NUM_VOICES-1:0][NOTE_ID_W-1:0] id_vec;
    logic [IDX_W:0]                      v;
    logic [IDX_W-1:0]                    vi, match_idx, free_idx, alloc_idx;
    logic signed [ACC_W-1:0]             acc;
    logic                                tick_pend, evt_fire, start;
    logic                                match_hit, free_hit, alloc_en;
`ifdef VOICE_STEAL_EN
    logic [NUM_VOICES-1:0][AGE_W-1:0]    age;
    logic [IDX_W-1:0]                    victim_idx;
`endif

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
        assign active_vec[g] = voice[g].active;
        assign id_vec[g]     = voice[g].note_id;
    end

    voice_alloc #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W)) u_alloc (
        .active    (active_vec),
        .ids       (id_vec),
`ifdef VOICE_STEAL_EN
        .ages      (age),
        .victim_idx(victim_idx),
`endif
        .note_id   (note_id_in),
        .match_vec (match_vec),
        .match_hit (match_hit),
        .match_idx (match_idx),
        .free_hit  (free_hit),
        .free_idx  (free_idx)
    );

    assign vi              = v[IDX_W-1:0];
    assign active_out      = active_vec;
    assign note_ready_out  = (state == S_IDLE);
    assign evt_fire        = note_valid_in && note_ready_out;
    // A tick that coincides with an event waits one cycle so the sweep sees the updated voices.
    assign start           = (state == S_IDLE) && (tick_pend || (sample_tick_in && !evt_fire));
    assign voice_phase_out = PHASE_BITS'(voice[vi].phase);

    always_comb begin
        alloc_en  = 1'b0;
        alloc_idx = free_idx;
        if (match_hit) begin
            alloc_en  = 1'b1;
            alloc_idx = match_idx;
        end else if (free_hit) begin
            alloc_en  = 1'b1;
            alloc_idx = free_idx;
        end
`ifdef VOICE_STEAL_EN
        else begin
            alloc_en  = 1'b1;
            alloc_idx = victim_idx;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        voice_valid_out = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = S_ISSUE;
            S_ISSUE: begin
                if (v == V_END) begin
                    state_nx = S_DONE;
                end else if (voice[vi].active) begin
                    voice_valid_out = 1'b1;
                    state_nx        = S_WAIT;
                end
            end
            S_WAIT:  if (wave_valid_in) state_nx = S_ISSUE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            voice         <= '0;
            v             <= '0;
            acc           <= '0;
            tick_pend     <= 1'b0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            overrun_out   <= 1'b0;
`ifdef VOICE_STEAL_EN
            age           <= '0;
`endif
        end else begin
            mix_valid_out <= 1'b0;
            if (sample_tick_in && state != S_IDLE) overrun_out <= 1'b1;
            if (state == S_IDLE) tick_pend <= sample_tick_in && evt_fire && !tick_pend;
`ifdef VOICE_STEAL_EN
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (sample_tick_in && voice[i].active && age[i] != '1) age[i] <= age[i] + 1'b1;
            end
`endif
            if (evt_fire) begin
                if (note_on_in) begin
                    if (alloc_en) begin
                        voice[alloc_idx].active  <= 1'b1;
                        voice[alloc_idx].note_id <= note_id_in;
                        voice[alloc_idx].incr    <= SYNTH_PHASE_ACC_BITS'(note_incr_in);
                        voice[alloc_idx].phase   <= '0;
`ifdef VOICE_STEAL_EN
                        age[alloc_idx]           <= '0;
`endif
                    end
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (match_vec[i]) voice[i].active <= 1'b0;
                    end
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= '0;
                        v   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (v != V_END) begin
                        if (voice[vi].active) voice[vi].phase <= voice[vi].phase + voice[vi].incr;
                        else                  v <= v + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wave_valid_in) begin
                        acc <= acc + ACC_W'(wave_sample_in);
                        v   <= v + 1'b1;
                    end
                end
                S_DONE: begin
                    mix_out       <= WIDTH'(acc >>> IDX_W);
                    mix_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
